// File: rtl/bju_pkg.sv
// Shared types and decode helpers for the branch/jump unit.
// Sits alongside the existing processor defines.
package bju_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpJal  = 4'd1,
    OpJalr = 4'd2,
    OpBeq  = 4'd3,
    OpBne  = 4'd4,
    OpBlt  = 4'd5,
    OpBge  = 4'd6,
    OpBltu = 4'd7,
    OpBgeu = 4'd8
  } bju_op_t;

  typedef enum logic {
    FlushIdle,
    FlushShadow
  } flush_state_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OpJal) || (op == OpJalr);
  endfunction

  // Encodings 9..15 fall outside both helpers, so they behave as NOP.
  function automatic logic is_branch(input logic [3:0] op);
    return (op >= OpBeq) && (op <= OpBgeu);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational condition evaluator for the six conditional branches.
module branch_cmp
  import bju_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (op)
      OpBeq:   cond = (a == b);
      OpBne:   cond = (a != b);
      OpBlt:   cond = ($signed(a) < $signed(b));
      OpBge:   cond = ($signed(a) >= $signed(b));
      OpBltu:  cond = (a < b);
      OpBgeu:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_jump_unit.sv
// Execute-stage resolver for JAL/JALR/branches with registered redirect and a flush shadow.
// Define BJU_MISALIGN_TRAP_EN to trap misaligned taken targets instead of redirecting.
module branch_jump_unit
  import bju_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = $clog2(FLUSH_DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output logic            o_rd_write_en,
  output logic [XLEN-1:0] o_rd_write_val,
  output logic            o_pc_update_en,
  output logic [XLEN-1:0] o_pc_update_val,
  output logic            o_flush,
`ifdef BJU_MISALIGN_TRAP_EN
  output logic            o_misalign,
  output logic [XLEN-1:0] o_bad_addr,
`endif
  output logic            o_taken
);

  localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FLUSH_DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  flush_state_t     state_q;
  logic             pc_en_q, wr_en_q;
  logic [XLEN-1:0]  pc_val_q, wr_val_q;

  logic            cond, jump, branch, ev, taken, misalign, redirect, write;
  logic [XLEN-1:0] sum_pc, sum_rs1, target, link;

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .op  (i_op),
    .a   (i_rs1_val),
    .b   (i_rs2_val),
    .cond(cond)
  );

  always_comb begin
    jump    = is_jump(i_op);
    branch  = is_branch(i_op);
    sum_pc  = i_pc + i_imm;
    sum_rs1 = i_rs1_val + i_imm;
    target  = (i_op == OpJalr) ? {sum_rs1[XLEN-1:1], 1'b0} : sum_pc;
    link    = i_pc + XLEN'(4);
    // Anything arriving inside the shadow is wrong-path and must not act.
    ev      = i_valid & ~i_stall & (cnt_q == '0);
    taken   = ev & (jump | (branch & cond));
`ifdef BJU_MISALIGN_TRAP_EN
    misalign = taken & (target[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    redirect = taken & ~misalign;
    write    = ev & jump & ~misalign;
    if (redirect) begin
      cnt_d = FlushLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      state_q  <= FlushIdle;
      pc_en_q  <= 1'b0;
      pc_val_q <= '0;
      wr_en_q  <= 1'b0;
      wr_val_q <= '0;
    end else if (!i_stall) begin
      cnt_q    <= cnt_d;
      state_q  <= (cnt_d != '0) ? FlushShadow : FlushIdle;
      pc_en_q  <= redirect;
      pc_val_q <= redirect ? target : '0;
      wr_en_q  <= write;
      wr_val_q <= write ? link : '0;
    end
  end

`ifdef BJU_MISALIGN_TRAP_EN
  logic            mis_q;
  logic [XLEN-1:0] bad_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else if (!i_stall) begin
      mis_q <= misalign;
      bad_q <= misalign ? target : '0;
    end
  end

  assign o_misalign = mis_q;
  assign o_bad_addr = bad_q;
`endif

  assign o_pc_update_en  = pc_en_q;
  assign o_taken         = pc_en_q;
  assign o_pc_update_val = pc_val_q;
  assign o_rd_write_en   = wr_en_q;
  assign o_rd_write_val  = wr_val_q;
  assign o_flush         = (state_q == FlushShadow);

endmodule

// File: tb/tb_branch_jump_unit.sv
// Directed self-checking bench for branch_jump_unit built with FLUSH_DEPTH=3.
module tb_branch_jump_unit;
  import bju_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FD   = 3;

  logic            i_clk, i_rst, i_valid, i_stall;
  logic [3:0]      i_op;
  logic [XLEN-1:0] i_pc, i_imm, i_rs1_val, i_rs2_val;
  logic            o_rd_write_en, o_pc_update_en, o_flush, o_taken;
  logic [XLEN-1:0] o_rd_write_val, o_pc_update_val;
`ifdef BJU_MISALIGN_TRAP_EN
  logic            o_misalign;
  logic [XLEN-1:0] o_bad_addr;
`endif

  int total = 0;
  int bad   = 0;
  int flush_cycles;

  branch_jump_unit #(
    .XLEN       (XLEN),
    .FLUSH_DEPTH(FD)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_stall        (i_stall),
    .i_op           (i_op),
    .i_pc           (i_pc),
    .i_imm          (i_imm),
    .i_rs1_val      (i_rs1_val),
    .i_rs2_val      (i_rs2_val),
    .o_rd_write_en  (o_rd_write_en),
    .o_rd_write_val (o_rd_write_val),
    .o_pc_update_en (o_pc_update_en),
    .o_pc_update_val(o_pc_update_val),
    .o_flush        (o_flush),
`ifdef BJU_MISALIGN_TRAP_EN
    .o_misalign     (o_misalign),
    .o_bad_addr     (o_bad_addr),
`endif
    .o_taken        (o_taken)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    i_valid   = 1'b1;
    i_op      = op;
    i_pc      = pc;
    i_imm     = imm;
    i_rs1_val = rs1;
    i_rs2_val = rs2;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_op    = OpNop;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_out(input string tag, input logic pc_en, input logic [XLEN-1:0] pc_val,
                         input logic wr_en, input logic [XLEN-1:0] wr_val, input logic fl);
    chk({tag, "_pc_en"}, XLEN'(o_pc_update_en), XLEN'(pc_en));
    chk({tag, "_pc_val"}, o_pc_update_val, pc_val);
    chk({tag, "_wr_en"}, XLEN'(o_rd_write_en), XLEN'(wr_en));
    chk({tag, "_wr_val"}, o_rd_write_val, wr_val);
    chk({tag, "_flush"}, XLEN'(o_flush), XLEN'(fl));
    chk({tag, "_taken"}, XLEN'(o_taken), XLEN'(pc_en));
  endtask

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_valid = 1'b0; i_op = OpNop;
    i_pc = '0; i_imm = '0; i_rs1_val = '0; i_rs2_val = '0;
    step();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    i_rst = 1'b0;

    // JAL: redirect to pc+imm, link pc+4, shadow of FD cycles
    drive(OpJal, 32'h100, 32'h20, 32'h0, 32'h0);
    step();
    chk_out("jal", 1'b1, 32'h120, 1'b1, 32'h104, 1'b1);
    idle(1);
    chk_out("jal_s1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(1);
    chk("jal_s2_flush", XLEN'(o_flush), 32'h1);
    idle(1);
    chk("jal_s3_flush", XLEN'(o_flush), 32'h0);

    // JALR clears bit 0 of the target
    drive(OpJalr, 32'h40, 32'h4, 32'h1001, 32'h0);
    step();
    chk_out("jalr", 1'b1, 32'h1004, 1'b1, 32'h44, 1'b1);
    idle(FD);

    // -1 vs 1: signed less-than holds, unsigned does not
    drive(OpBlt, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    step();
    chk_out("blt", 1'b1, 32'h240, 1'b0, 32'h0, 1'b1);
    idle(FD);
    drive(OpBge, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    step();
    chk_out("bge", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(OpBltu, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    step();
    chk_out("bltu", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(OpBgeu, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    step();
    chk_out("bgeu", 1'b1, 32'h240, 1'b0, 32'h0, 1'b1);
    idle(FD);
    drive(OpBeq, 32'h300, 32'hFFFF_FFF8, 32'h5, 32'h5);
    step();
    chk_out("beq", 1'b1, 32'h2F8, 1'b0, 32'h0, 1'b1);
    idle(FD);
    drive(OpBne, 32'h300, 32'h10, 32'h5, 32'h5);
    step();
    chk_out("bne_nt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(4'd12, 32'h300, 32'h10, 32'h5, 32'h5);
    step();
    chk_out("op12", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Wrong-path JALs in the shadow are squashed; the one after it redirects
    drive(OpBne, 32'h400, 32'h10, 32'h1, 32'h2);
    step();
    chk_out("bne_t", 1'b1, 32'h410, 1'b0, 32'h0, 1'b1);
    drive(OpJal, 32'h500, 32'h8, 32'h0, 32'h0);
    step();
    chk_out("sq1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    chk_out("sq2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    chk_out("sq3", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_out("after_sq", 1'b1, 32'h508, 1'b1, 32'h504, 1'b1);
    idle(FD);

    // Stall mid-shadow freezes the pulse and counter
    drive(OpJal, 32'h600, 32'h0, 32'h0, 32'h0);
    step();
    flush_cycles = o_flush ? 1 : 0;
    i_stall = 1'b1;
    drive(OpJal, 32'h700, 32'h4, 32'h0, 32'h0);
    step();
    chk_out("stall1", 1'b1, 32'h600, 1'b1, 32'h604, 1'b1);
    if (o_flush) flush_cycles++;
    step();
    chk_out("stall2", 1'b1, 32'h600, 1'b1, 32'h604, 1'b1);
    if (o_flush) flush_cycles++;
    i_stall = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_flush) flush_cycles++;
    end
    chk("stall_flush_len", XLEN'(flush_cycles), XLEN'(FD + 2));

    // Async reset between edges clears everything at once
    drive(OpJal, 32'h700, 32'h10, 32'h0, 32'h0);
    step();
    chk("pre_rst_flush", XLEN'(o_flush), 32'h1);
    #2 i_rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    i_rst = 1'b0;
    drive(OpJal, 32'h800, 32'h4, 32'h0, 32'h0);
    step();
    chk_out("post_rst", 1'b1, 32'h804, 1'b1, 32'h804, 1'b1);
    idle(FD);

`ifdef BJU_MISALIGN_TRAP_EN
    drive(OpJalr, 32'h40, 32'h4, 32'h1002, 32'h0);
    step();
    chk("mis_flag", XLEN'(o_misalign), 32'h1);
    chk("mis_addr", o_bad_addr, 32'h1006);
    chk_out("mis", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1);
    chk("mis_pulse", XLEN'(o_misalign), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
